// File: rtl/apb_wait_completer.sv
// APB completer with a DEPTH-word register file, byte-strobe writes and WAITS wait states.
// Optional macro APB_SLVERR_EN: out-of-range indices answer with PSLVERR=1.
module apb_wait_completer #(
   parameter int ADDWIDTH  = 8,
   parameter int DATAWIDTH = 32,
   parameter int DEPTH     = 16,
   parameter int WAITS     = 2
) (
   input  logic                   PCLK,
   input  logic                   PRESETn,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [ADDWIDTH-1:0]    PADDR,
   input  logic [DATAWIDTH-1:0]   PWDATA,
   input  logic [DATAWIDTH/8-1:0] PSTRB,
   output logic                   PREADY,
   output logic [DATAWIDTH-1:0]   PRDATA,
   output logic                   PSLVERR
);

   localparam int NBYTES = DATAWIDTH / 8;
   localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // The counter holds the waits still to be spent after the first access cycle.
   localparam logic [3:0]        WAIT_LOAD = 4'((WAITS > 0) ? WAITS - 1 : 0);
   localparam logic [ADDWIDTH:0] DEPTH_W   = (ADDWIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                 r_state;
   logic [3:0]             r_cnt;
   logic [ADDWIDTH-1:0]    r_addr;
   logic                   r_write;
   logic [DATAWIDTH-1:0]   r_wdata;
   logic [NBYTES-1:0]      r_strb;
   logic                   r_pready;
   logic [DATAWIDTH-1:0]   r_prdata;
   logic                   r_pslverr;
   logic [DATAWIDTH-1:0]   r_mem [DEPTH];

   logic [ADDWIDTH-1:0]    w_rsp_addr;
   logic                   w_rsp_write;
   logic                   w_rsp_valid;
   logic [IDXW-1:0]        w_rsp_idx;
   logic [DATAWIDTH-1:0]   w_rsp_data;
   logic                   w_rsp_err;
   logic                   w_wr_valid;
   logic                   w_commit;
   logic [IDXW-1:0]        w_wr_idx;
   logic [DATAWIDTH-1:0]   w_bmask;

   // With WAITS=0 the response is built in the setup cycle, before the capture registers load.
   assign w_rsp_addr  = (r_state == S_IDLE) ? PADDR  : r_addr;
   assign w_rsp_write = (r_state == S_IDLE) ? PWRITE : r_write;
   assign w_rsp_valid = ({1'b0, w_rsp_addr} < DEPTH_W);
   assign w_rsp_idx   = w_rsp_addr[IDXW-1:0];
   assign w_rsp_data  = (w_rsp_valid && !w_rsp_write) ? r_mem[w_rsp_idx] : '0;
`ifdef APB_SLVERR_EN
   assign w_rsp_err   = !w_rsp_valid;
`else
   assign w_rsp_err   = 1'b0;
`endif

   assign w_wr_valid = ({1'b0, r_addr} < DEPTH_W);
   assign w_commit   = (r_state == S_RESP) && r_write && w_wr_valid;
   assign w_wr_idx   = r_addr[IDXW-1:0];

   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bmask
         assign w_bmask[gi*8 +: 8] = {8{r_strb[gi]}};
      end
   endgenerate

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int w = 0; w < DEPTH; w++) begin
            r_mem[w] <= '0;
         end
      end else if (w_commit) begin
         r_mem[w_wr_idx] <= (r_mem[w_wr_idx] & ~w_bmask) | (r_wdata & w_bmask);
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_write   <= 1'b0;
         r_wdata   <= '0;
         r_strb    <= '0;
         r_pready  <= 1'b0;
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_pready  <= 1'b0;
               r_pslverr <= 1'b0;
               if (PSEL && !PENABLE) begin
                  r_addr  <= PADDR;
                  r_write <= PWRITE;
                  r_wdata <= PWDATA;
                  r_strb  <= PSTRB;
                  if (WAITS == 0) begin
                     r_state   <= S_RESP;
                     r_pready  <= 1'b1;
                     r_prdata  <= w_rsp_data;
                     r_pslverr <= w_rsp_err;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= WAIT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (!PSEL) begin
                  r_state <= S_IDLE;
               end else if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state   <= S_RESP;
                  r_pready  <= 1'b1;
                  r_prdata  <= w_rsp_data;
                  r_pslverr <= w_rsp_err;
               end
            end
            S_RESP: begin
               r_state   <= S_IDLE;
               r_pready  <= 1'b0;
               r_pslverr <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               r_pready  <= 1'b0;
               r_pslverr <= 1'b0;
            end
         endcase
      end
   end

   assign PREADY  = r_pready;
   assign PRDATA  = r_prdata;
   assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_wait_completer.sv
// Directed bench for apb_wait_completer: a WAITS=2 instance and a WAITS=0 instance on a shared bus.
module tb_apb_wait_completer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel2, psel0, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready2, pslverr2, pready0, pslverr0;
   logic [31:0] prdata2, prdata0;

   int n_vec = 0;
   int n_bad = 0;

`ifdef APB_SLVERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   apb_wait_completer #(.ADDWIDTH(8), .DATAWIDTH(32), .DEPTH(16), .WAITS(2)) u_w2 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PREADY(pready2), .PRDATA(prdata2), .PSLVERR(pslverr2)
   );

   apb_wait_completer #(.ADDWIDTH(8), .DATAWIDTH(32), .DEPTH(16), .WAITS(0)) u_w0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0)
   );

   typedef struct {
      bit          d0;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit d0, bit wr, logic [7:0] a, logic [31:0] wd, logic [3:0] st,
                               logic [31:0] exp_rd, logic exp_err);
      vec_t v;
      v.d0 = d0; v.wr = wr; v.addr = a; v.wdata = wd; v.strb = st;
      v.exp_rd = exp_rd; v.exp_err = exp_err;
      vecs.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Caller is #1 after a rising edge; this cycle becomes the setup cycle T0.
   task automatic xfer(input bit d0, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err);
      int          waits;
      bit          tim_ok;
      logic [31:0] rd;
      logic        err;
      waits  = d0 ? 0 : 2;
      tim_ok = 1'b1;
      psel0 = d0; psel2 = !d0; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
      @(posedge clk); #1;
      // Scramble the address-phase signals; the completer must use the captured values.
      penable = 1'b1; pwrite = !wr; paddr = ~a; pwdata = ~wd; pstrb = ~st;
      for (int k = 0; k <= waits; k++) begin
         @(negedge clk);
         if ((d0 ? pready0 : pready2) !== (k == waits)) tim_ok = 1'b0;
         if (k < waits) begin
            @(posedge clk); #1;
         end
      end
      rd  = d0 ? prdata0 : prdata2;
      err = d0 ? pslverr0 : pslverr2;
      @(posedge clk); #1;
      psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
      if ((d0 ? pready0 : pready2) !== 1'b0) tim_ok = 1'b0;
      check("ready_timing", {31'd0, tim_ok}, 32'd1);
      if (!wr) check("prdata", rd, exp_rd);
      check("pslverr", {31'd0, err}, {31'd0, exp_err});
      $display("xfer waits=%0d %s idx=%0d wdata=0x%08h strb=%b -> prdata=0x%08h pslverr=%b",
               waits, wr ? "WR" : "RD", a, wd, st, rd, err);
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0; psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;

      // Vector table: WAITS=2 instance.
      for (int i = 0; i < 16; i++) add(0, 0, 8'(i), 0, 0, 32'h0, 1'b0);
      add(0, 1, 3,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0);
      add(0, 0, 3,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);
      add(0, 1, 3,  32'h11223344, 4'b0101, 32'h0,        1'b0);
      add(0, 0, 3,  32'h0,        4'b1111, 32'hDE22BE44, 1'b0);
      add(0, 1, 3,  32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0);
      add(0, 1, 15, 32'h0BADF00D, 4'b1000, 32'h0,        1'b0);
      add(0, 0, 15, 32'h0,        4'b0000, 32'h0B000000, 1'b0);
      add(0, 1, 20, 32'hFFFFFFFF, 4'b1111, 32'h0,        EXP_ERR);
      add(0, 0, 20, 32'h0,        4'b0000, 32'h0,        EXP_ERR);
      add(0, 0, 16, 32'h0,        4'b0000, 32'h0,        EXP_ERR);
      add(0, 0, 255,32'h0,        4'b0000, 32'h0,        EXP_ERR);
      for (int i = 0; i < 16; i++)
         add(0, 0, 8'(i), 0, 0, (i == 3) ? 32'hDE22BE44 : (i == 15) ? 32'h0B000000 : 32'h0, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      check("reset_pready",  {31'd0, pready2},  32'd0);
      check("reset_prdata",  prdata2,           32'd0);
      check("reset_pslverr", {31'd0, pslverr2}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++)
         xfer(vecs[i].d0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
              vecs[i].exp_rd, vecs[i].exp_err);

      // Abort: PSEL dropped in the first access cycle of a write.
      psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
      @(posedge clk); #1;
      psel2 = 1'b0;
      ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (pready2 !== 1'b0) ok = 1'b0;
      end
      check("abort_no_ready", {31'd0, ok}, 32'd1);
      $display("abort write idx=5 at T1");
      @(posedge clk); #1;
      xfer(0, 0, 5, 0, 0, 32'h0, 1'b0);

      // Protocol violation: PENABLE high with PSEL while idle.
      psel2 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 3;
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (pready2 !== 1'b0) ok = 1'b0;
      end
      check("penable_in_idle", {31'd0, ok}, 32'd1);
      $display("protocol violation PENABLE=1 in IDLE");
      @(posedge clk); #1;
      psel2 = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      xfer(0, 0, 3, 0, 0, 32'hDE22BE44, 1'b0);

      // WAITS=0 instance: back-to-back transfers with no idle cycle between them.
      xfer(1, 1, 1,  32'h01010101, 4'hF, 32'h0, 1'b0);
      xfer(1, 1, 2,  32'h02020202, 4'hF, 32'h0, 1'b0);
      xfer(1, 0, 1,  32'h0,        4'h0, 32'h01010101, 1'b0);
      xfer(1, 0, 2,  32'h0,        4'h0, 32'h02020202, 1'b0);
      xfer(1, 1, 2,  32'hAABBCCDD, 4'b0011, 32'h0, 1'b0);
      xfer(1, 0, 2,  32'h0,        4'h0, 32'h0202CCDD, 1'b0);
      xfer(1, 0, 9,  32'h0,        4'h0, 32'h0, 1'b0);
      xfer(1, 0, 30, 32'h0,        4'h0, 32'h0, EXP_ERR);
      @(posedge clk); #1;

      // Reset during the completion cycle of a WAITS=0 read.
      check("prdata_hold", prdata2, 32'hDE22BE44);
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 1;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check("rst_pre_ready", {31'd0, pready0}, 32'd1);
      check("rst_pre_data",  prdata0,          32'h01010101);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_ready",  {31'd0, pready0},  32'd0);
      check("rst_async_data",   prdata0,           32'd0);
      check("rst_async_err",    {31'd0, pslverr0}, 32'd0);
      check("rst_async_data_w2", prdata2,          32'd0);
      $display("async reset mid-transfer");
      psel0 = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(1, 0, 1,  0, 0, 32'h0, 1'b0);
      xfer(1, 0, 2,  0, 0, 32'h0, 1'b0);
      xfer(0, 0, 3,  0, 0, 32'h0, 1'b0);
      xfer(0, 0, 15, 0, 0, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
